// File: rtl/charis_pkg.sv
// Shared CHARIS encodings: opcodes, R-type func class, ALU and immediate-extension
// codes, controller state encoding and the control/op-class bundles.
package charis_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b100000;
    localparam logic [5:0] OP_LI    = 6'b111000;
    localparam logic [5:0] OP_LUI   = 6'b111001;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_ANDI  = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_B     = 6'b111111;
    localparam logic [5:0] OP_BEQ   = 6'b000000;
    localparam logic [5:0] OP_BNE   = 6'b000001;
    localparam logic [5:0] OP_LB    = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_SB    = 6'b000111;
    localparam logic [5:0] OP_SW    = 6'b011111;

    // Every defined R-type func has 11 in its top two bits.
    localparam logic [1:0] FUNC_CLASS = 2'b11;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;

    localparam logic [1:0] IMM_SEXT     = 2'b00;
    localparam logic [1:0] IMM_ZEXT     = 2'b01;
    localparam logic [1:0] IMM_HI16     = 2'b10;
    localparam logic [1:0] IMM_SEXT_SH2 = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC     = 4'd2,
        S_WB_ALU   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_WB_MEM   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_BRANCH   = 4'd8
    } state_e;

    typedef struct packed {
        logic is_rtype;
        logic is_imm;
        logic is_load;
        logic is_store;
        logic is_branch;
        logic is_byte;
        logic illegal;
    } opclass_t;

    typedef struct packed {
        logic       ir_ld_en;
        logic       pc_ld_en;
        logic       pc_sel;
        logic       rf_b_sel;
        logic       reg_ab_ld_en;
        logic [1:0] imm_ext;
        logic       alu_bin_sel;
        logic [3:0] alu_func;
        logic       alu_out_ld_en;
        logic       mem_wr_en;
        logic       byte_op;
        logic       mem_out_ld_en;
        logic       rf_wr_en;
        logic       rf_wr_data_sel;
        logic       illegal;
    } ctrl_t;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/ctrl_opclass.sv
// Combinational instruction classifier: sorts the IR contents into the
// controller's dispatch classes and flags undefined opcode/func combinations.
module ctrl_opclass
    import charis_pkg::*;
(
    input  logic [31:0] instr_i,
    output opclass_t    class_o
);

    logic [5:0] op;
    logic [5:0] func;
    logic       rtype_ok;
    logic       unused_fields;

    assign op            = opcode_of(instr_i);
    assign func          = instr_i[5:0];
    assign unused_fields = ^instr_i[25:6];

    always_comb begin
        class_o           = '0;
        class_o.is_rtype  = (op == OP_RTYPE);
        class_o.is_imm    = (op == OP_LI)   || (op == OP_LUI) || (op == OP_ADDI) ||
                            (op == OP_ANDI) || (op == OP_ORI);
        class_o.is_load   = (op == OP_LW)   || (op == OP_LB);
        class_o.is_store  = (op == OP_SW)   || (op == OP_SB);
        class_o.is_branch = (op == OP_B)    || (op == OP_BEQ) || (op == OP_BNE);
        class_o.is_byte   = (op == OP_LB)   || (op == OP_SB);
        rtype_ok          = class_o.is_rtype && (func[5:4] == FUNC_CLASS);
        class_o.illegal   = !(rtype_ok || class_o.is_imm || class_o.is_load ||
                              class_o.is_store || class_o.is_branch);
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle CHARIS controller: one phase per cycle from FETCH back to FETCH,
// with datapath controls decoded from the current state and the latched IR.
module multicycle_control
    import charis_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [31:0] Instr,
    input  logic        ALU_zero,
    output logic        IR_LdEn,
    output logic        PC_LdEn,
    output logic        PC_sel,
    output logic        RF_B_sel,
    output logic        RegAB_LdEn,
    output logic [1:0]  ImmExt,
    output logic        ALU_Bin_sel,
    output logic [3:0]  ALU_func,
    output logic        ALUout_LdEn,
    output logic        MEM_WrEn,
    output logic        ByteOp,
    output logic        MEMout_LdEn,
    output logic        RF_WrEn,
    output logic        RF_WrData_sel,
    output logic        Illegal
);

    state_e     state_q, state_d;
    logic       running_q;
    opclass_t   cls;
    ctrl_t      ctrl;
    logic [5:0] opcode;

    assign opcode = opcode_of(Instr);

    ctrl_opclass u_opclass (
        .instr_i (Instr),
        .class_o (cls)
    );

    // running_q holds the controller quiet for the first edge after reset
    // release, so FETCH begins on the edge following deassertion.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_FETCH;
            running_q <= 1'b0;
        end else begin
            running_q <= 1'b1;
            if (running_q) begin
                state_q <= state_d;
            end
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                if (cls.illegal)                      state_d = S_FETCH;
                else if (cls.is_rtype || cls.is_imm)  state_d = S_EXEC;
                else if (cls.is_branch)               state_d = S_BRANCH;
                else                                  state_d = S_MEM_ADDR;
            end
            S_EXEC:     state_d = S_WB_ALU;
            S_MEM_ADDR: state_d = cls.is_load ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = S_WB_MEM;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ctrl = '0;
        if (running_q) begin
            case (state_q)
                S_FETCH: ctrl.ir_ld_en = 1'b1;
                S_DECODE: begin
                    ctrl.reg_ab_ld_en = 1'b1;
                    ctrl.rf_b_sel     = (opcode == OP_BEQ) || (opcode == OP_BNE) ||
                                        (opcode == OP_SW)  || (opcode == OP_SB);
                    ctrl.pc_ld_en     = cls.illegal;
                    ctrl.illegal      = cls.illegal;
                end
                S_EXEC: begin
                    ctrl.alu_out_ld_en = 1'b1;
                    ctrl.alu_bin_sel   = !cls.is_rtype;
                    if (cls.is_rtype)              ctrl.alu_func = Instr[3:0];
                    else if (opcode == OP_ANDI)    ctrl.alu_func = ALU_AND;
                    else if (opcode == OP_ORI)     ctrl.alu_func = ALU_OR;
                    else                           ctrl.alu_func = ALU_ADD;
                    if (cls.is_rtype)                                 ctrl.imm_ext = IMM_SEXT;
                    else if (opcode == OP_ANDI || opcode == OP_ORI)   ctrl.imm_ext = IMM_ZEXT;
                    else if (opcode == OP_LUI)                        ctrl.imm_ext = IMM_HI16;
                    else                                              ctrl.imm_ext = IMM_SEXT;
                end
                S_WB_ALU: begin
                    ctrl.rf_wr_en = 1'b1;
                    ctrl.pc_ld_en = 1'b1;
                end
                S_MEM_ADDR: begin
                    ctrl.alu_func      = ALU_ADD;
                    ctrl.alu_bin_sel   = 1'b1;
                    ctrl.imm_ext       = IMM_SEXT;
                    ctrl.alu_out_ld_en = 1'b1;
                    ctrl.byte_op       = cls.is_byte;
                end
                S_MEM_RD: begin
                    ctrl.mem_out_ld_en = 1'b1;
                    ctrl.byte_op       = cls.is_byte;
                end
                S_WB_MEM: begin
                    ctrl.rf_wr_en       = 1'b1;
                    ctrl.rf_wr_data_sel = 1'b1;
                    ctrl.pc_ld_en       = 1'b1;
                end
                S_MEM_WR: begin
                    ctrl.mem_wr_en = 1'b1;
                    ctrl.byte_op   = cls.is_byte;
                    ctrl.pc_ld_en  = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.alu_func = ALU_SUB;
                    ctrl.imm_ext  = IMM_SEXT_SH2;
                    ctrl.pc_ld_en = 1'b1;
                    // Only Mealy output: the branch decision follows the live zero flag.
                    if (opcode == OP_B)        ctrl.pc_sel = 1'b1;
                    else if (opcode == OP_BEQ) ctrl.pc_sel = ALU_zero;
                    else                       ctrl.pc_sel = !ALU_zero;
                end
                default: ctrl = '0;
            endcase
        end
    end

    assign IR_LdEn       = ctrl.ir_ld_en;
    assign PC_LdEn       = ctrl.pc_ld_en;
    assign PC_sel        = ctrl.pc_sel;
    assign RF_B_sel      = ctrl.rf_b_sel;
    assign RegAB_LdEn    = ctrl.reg_ab_ld_en;
    assign ImmExt        = ctrl.imm_ext;
    assign ALU_Bin_sel   = ctrl.alu_bin_sel;
    assign ALU_func      = ctrl.alu_func;
    assign ALUout_LdEn   = ctrl.alu_out_ld_en;
    assign MEM_WrEn      = ctrl.mem_wr_en;
    assign ByteOp        = ctrl.byte_op;
    assign MEMout_LdEn   = ctrl.mem_out_ld_en;
    assign RF_WrEn       = ctrl.rf_wr_en;
    assign RF_WrData_sel = ctrl.rf_wr_data_sel;
    assign Illegal       = ctrl.illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed and random instructions checked cycle by
// cycle against a per-instruction phase table built from the instruction set rules.
module tb_multicycle_control;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [31:0] Instr = 32'h0;
    logic        ALU_zero = 1'b0;
    logic        IR_LdEn, PC_LdEn, PC_sel, RF_B_sel, RegAB_LdEn;
    logic [1:0]  ImmExt;
    logic        ALU_Bin_sel;
    logic [3:0]  ALU_func;
    logic        ALUout_LdEn, MEM_WrEn, ByteOp, MEMout_LdEn, RF_WrEn, RF_WrData_sel, Illegal;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic       ir; logic pcld; logic pcsel; logic bsel; logic abld;
        logic [1:0] imm; logic binsel; logic [3:0] func; logic aluld;
        logic       memwr; logic byteop; logic memld; logic rfwr; logic wdsel; logic ill;
    } exp_t;

    exp_t act;
    assign act = {IR_LdEn, PC_LdEn, PC_sel, RF_B_sel, RegAB_LdEn, ImmExt, ALU_Bin_sel,
                  ALU_func, ALUout_LdEn, MEM_WrEn, ByteOp, MEMout_LdEn, RF_WrEn,
                  RF_WrData_sel, Illegal};

    localparam int K_ILL = 0, K_R = 1, K_IMM = 2, K_BR = 3, K_LD = 4, K_ST = 5;

    localparam logic [5:0] T_R = 6'b100000, T_LI = 6'b111000, T_LUI = 6'b111001,
                           T_ADDI = 6'b110000, T_ANDI = 6'b110010, T_ORI = 6'b110011,
                           T_B = 6'b111111, T_BEQ = 6'b000000, T_BNE = 6'b000001,
                           T_LB = 6'b000011, T_LW = 6'b001111, T_SB = 6'b000111,
                           T_SW = 6'b011111;

    multicycle_control dut (
        .Clk(Clk), .Reset_n(Reset_n), .Instr(Instr), .ALU_zero(ALU_zero),
        .IR_LdEn(IR_LdEn), .PC_LdEn(PC_LdEn), .PC_sel(PC_sel), .RF_B_sel(RF_B_sel),
        .RegAB_LdEn(RegAB_LdEn), .ImmExt(ImmExt), .ALU_Bin_sel(ALU_Bin_sel),
        .ALU_func(ALU_func), .ALUout_LdEn(ALUout_LdEn), .MEM_WrEn(MEM_WrEn),
        .ByteOp(ByteOp), .MEMout_LdEn(MEMout_LdEn), .RF_WrEn(RF_WrEn),
        .RF_WrData_sel(RF_WrData_sel), .Illegal(Illegal)
    );

    always #5 Clk = ~Clk;

    function automatic int kind_of(input logic [31:0] ins);
        logic [5:0] op;
        op = ins[31:26];
        if (op == T_R) return (ins[5:4] == 2'b11) ? K_R : K_ILL;
        if (op == T_LI || op == T_LUI || op == T_ADDI || op == T_ANDI || op == T_ORI) return K_IMM;
        if (op == T_B || op == T_BEQ || op == T_BNE) return K_BR;
        if (op == T_LW || op == T_LB) return K_LD;
        if (op == T_SW || op == T_SB) return K_ST;
        return K_ILL;
    endfunction

    function automatic int latency(input logic [31:0] ins);
        case (kind_of(ins))
            K_ILL:   return 2;
            K_BR:    return 3;
            K_LD:    return 5;
            default: return 4;
        endcase
    endfunction

    // Expected controls for phase k (0 = fetch) of one instruction.
    function automatic exp_t exp_cycle(input logic [31:0] ins, input int k, input logic z);
        exp_t e;
        logic [5:0] op;
        int kind;
        logic is_byte;
        e = '0;
        op = ins[31:26];
        kind = kind_of(ins);
        is_byte = (op == T_LB) || (op == T_SB);
        if (k == 0) begin
            e.ir = 1'b1;
        end else if (k == 1) begin
            e.abld = 1'b1;
            e.bsel = (op == T_BEQ) || (op == T_BNE) || (op == T_SW) || (op == T_SB);
            if (kind == K_ILL) begin e.pcld = 1'b1; e.ill = 1'b1; end
        end else if (kind == K_R || kind == K_IMM) begin
            if (k == 2) begin
                e.aluld = 1'b1;
                e.binsel = (kind == K_IMM);
                e.func = (kind == K_R) ? ins[3:0] : (op == T_ANDI) ? 4'd2 : (op == T_ORI) ? 4'd3 : 4'd0;
                e.imm = (kind == K_R) ? 2'b00 : (op == T_ANDI || op == T_ORI) ? 2'b01 :
                        (op == T_LUI) ? 2'b10 : 2'b00;
            end else begin
                e.rfwr = 1'b1; e.pcld = 1'b1;
            end
        end else if (kind == K_BR) begin
            e.func = 4'd1; e.imm = 2'b11; e.pcld = 1'b1;
            e.pcsel = (op == T_B) ? 1'b1 : (op == T_BEQ) ? z : !z;
        end else begin
            if (k == 2) begin
                e.binsel = 1'b1; e.aluld = 1'b1; e.byteop = is_byte;
            end else if (kind == K_ST) begin
                e.memwr = 1'b1; e.byteop = is_byte; e.pcld = 1'b1;
            end else if (k == 3) begin
                e.memld = 1'b1; e.byteop = is_byte;
            end else begin
                e.rfwr = 1'b1; e.wdsel = 1'b1; e.pcld = 1'b1;
            end
        end
        return e;
    endfunction

    // Starts 1 time unit after the edge that enters FETCH; returns at the same point
    // of the next FETCH. zmode 0/1 forces ALU_zero, 2 randomises it each cycle.
    task automatic run_instr(input logic [31:0] ins, input int zmode, input string name);
        int n;
        exp_t e;
        n = latency(ins);
        for (int k = 0; k < n; k++) begin
            Instr = (k == 0) ? $urandom : ins;
            ALU_zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            @(negedge Clk);
            e = exp_cycle(ins, k, ALU_zero);
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL %s cyc=%0d instr=%h zero=%b got=%b want=%b",
                         name, k + 1, ins, ALU_zero, act, e);
            end
            @(posedge Clk); #1;
        end
        $display("txn %-8s instr=%h cycles=%0d", name, ins, n);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (act !== exp_t'(0)) begin
            failures++; $display("FAIL reset_held got=%b want=%b", act, exp_t'(0));
        end
        Reset_n = 1'b1;
        #1;
        checks++;
        if (act !== exp_t'(0)) begin
            failures++; $display("FAIL reset_release got=%b want=%b", act, exp_t'(0));
        end
        @(posedge Clk); #1;
        $display("txn reset    released");
    endtask

    task automatic test_directed();
        run_instr(32'hE0018002, 2, "li");
        run_instr(32'h80231030, 2, "add");
        run_instr(32'h00220004, 1, "beq_z1");
        run_instr(32'h00220004, 0, "beq_z0");
        run_instr(32'h04220004, 0, "bne_z0");
        run_instr(32'hFC000010, 0, "b");
        run_instr(32'h3C220008, 2, "lw");
        run_instr(32'h0C220008, 2, "lb");
        run_instr(32'h1C220000, 2, "sb");
        run_instr(32'h7C220004, 2, "sw");
        run_instr(32'hE4010001, 2, "lui");
        run_instr(32'hC8221234, 2, "andi");
        run_instr(32'hCC221234, 2, "ori");
        run_instr(32'h54000000, 2, "illegal");
        run_instr(32'h80231021, 2, "bad_func");
    endtask

    task automatic test_random();
        logic [5:0] ops [13];
        logic [5:0] op;
        logic [31:0] ins;
        ops = '{T_R, T_LI, T_LUI, T_ADDI, T_ANDI, T_ORI, T_B, T_BEQ, T_BNE, T_LB, T_LW, T_SB, T_SW};
        for (int i = 0; i < 200; i++) begin
            op = ($urandom_range(0, 9) < 7) ? ops[$urandom_range(0, 12)] : 6'($urandom);
            ins = {op, 26'($urandom)};
            if (op == T_R && $urandom_range(0, 3) != 0) ins[5:4] = 2'b11;
            run_instr(ins, 2, "random");
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] ins;
        exp_t e;
        ins = 32'h7C220004;
        for (int k = 0; k < 3; k++) begin
            Instr = (k == 0) ? $urandom : ins;
            ALU_zero = 1'b0;
            @(negedge Clk);
            e = exp_cycle(ins, k, ALU_zero);
            checks++;
            if (act !== e) begin
                failures++; $display("FAIL mid_pre cyc=%0d got=%b want=%b", k + 1, act, e);
            end
            if (k < 2) begin @(posedge Clk); #1; end
        end
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if (act !== exp_t'(0)) begin
            failures++; $display("FAIL mid_async_clear got=%b want=%b", act, exp_t'(0));
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge Clk);
            checks++;
            if (act !== exp_t'(0)) begin
                failures++; $display("FAIL mid_held cyc=%0d got=%b want=%b", c, act, exp_t'(0));
            end
        end
        Reset_n = 1'b1;
        #1;
        checks++;
        if (act !== exp_t'(0)) begin
            failures++; $display("FAIL mid_release got=%b want=%b", act, exp_t'(0));
        end
        @(posedge Clk); #1;
        $display("txn reset    during sw MEM_ADDR");
        run_instr(ins, 2, "sw_after");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
